// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and address type for the multiport register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_RD_DEF   = 2;

  // Single-register files still need a one-bit address.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned AW_DEF = addr_width(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers, with the WAW issue stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_a,
  input  logic [AW-1:0]       clr_reg_a,
  input  logic                clr_b,
  input  logic [AW-1:0]       clr_reg_b,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_reg,
  output logic                issue_stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_d, busy_q;

  // A new issue outranks a retiring write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if ((clr_a && clr_reg_a == AW'(r)) || (clr_b && clr_reg_b == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (issue_valid && issue_reg == AW'(r)) begin
        busy_d[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign issue_stall = issue_valid && busy_q[issue_reg];

endmodule

// File: rtl/multiport_register_file.sv
// Two-write, N-read register file with priority writes, optional bypass and busy scoreboard.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW = addr_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_write_a,
  input  logic [AW-1:0]          write_reg_a,
  input  logic [XLEN-1:0]        write_data_a,
  input  logic                   wb_clear_a,
  input  logic                   reg_write_b,
  input  logic [AW-1:0]          write_reg_b,
  input  logic [XLEN-1:0]        write_data_b,
  input  logic                   wb_clear_b,
  input  logic [NUM_RD*AW-1:0]   read_reg,
  output logic [NUM_RD*XLEN-1:0] read_data,
  output logic [NUM_RD-1:0]      read_busy,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_reg,
  output logic                   issue_stall,
  output logic                   wr_conflict
);

  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic                wr_conflict_d, wr_conflict_q;
  logic                we_a, we_b;
  logic [NUM_REGS-1:0] busy;

  assign we_a = reg_write_a && !((ZERO_REG != 0) && write_reg_a == '0);
  assign we_b = reg_write_b && !((ZERO_REG != 0) && write_reg_b == '0);

  // Port B is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (we_a) regs_d[write_reg_a] = write_data_a;
    if (we_b) regs_d[write_reg_b] = write_data_b;
    wr_conflict_d = reg_write_a && reg_write_b && (write_reg_a == write_reg_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_a       (reg_write_a && wb_clear_a),
    .clr_reg_a   (write_reg_a),
    .clr_b       (reg_write_b && wb_clear_b),
    .clr_reg_b   (write_reg_b),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_stall (issue_stall),
    .busy        (busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data_c;
    logic            busy_c;

    assign addr = read_reg[i*AW +: AW];

    // Forwarded write data goes with a cleared busy flag so the consumer can proceed.
    always_comb begin
      data_c = regs_q[addr];
      busy_c = busy[addr];
      if (BYPASS != 0) begin
        if (we_a && write_reg_a == addr) data_c = write_data_a;
        if (we_b && write_reg_b == addr) data_c = write_data_b;
        if ((reg_write_a && wb_clear_a && write_reg_a == addr) ||
            (reg_write_b && wb_clear_b && write_reg_b == addr)) begin
          busy_c = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && addr == '0) begin
        data_c = '0;
        busy_c = 1'b0;
      end
    end

    assign read_data[i*XLEN +: XLEN] = data_c;
    assign read_busy[i]              = busy_c;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: per-cycle vector table plus a hand-written asynchronous reset sequence.
module tb_multiport_register_file;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        reg_write_a, wb_clear_a, reg_write_b, wb_clear_b, issue_valid;
  logic [4:0]  write_reg_a, write_reg_b, issue_reg;
  logic [31:0] write_data_a, write_data_b;
  logic [9:0]  read_reg;
  logic [63:0] read_data, read_data_nb;
  logic [1:0]  read_busy, read_busy_nb;
  logic        issue_stall, issue_stall_nb, wr_conflict, wr_conflict_nb;

  int n_checks = 0;
  int n_fail   = 0;

  multiport_register_file #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_a(reg_write_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .wb_clear_a(wb_clear_a),
    .reg_write_b(reg_write_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .wb_clear_b(wb_clear_b),
    .read_reg(read_reg), .read_data(read_data), .read_busy(read_busy),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_stall(issue_stall),
    .wr_conflict(wr_conflict)
  );

  multiport_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .reg_write_a(reg_write_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .wb_clear_a(wb_clear_a),
    .reg_write_b(reg_write_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .wb_clear_b(wb_clear_b),
    .read_reg(read_reg), .read_data(read_data_nb), .read_busy(read_busy_nb),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_stall(issue_stall_nb),
    .wr_conflict(wr_conflict_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wa;  logic [4:0] aa; logic [31:0] da; logic ca;
    logic        wb;  logic [4:0] ab; logic [31:0] db; logic cb;
    logic        iv;  logic [4:0] ir;
    logic [4:0]  r0;  logic [4:0] r1;
    logic [31:0] e0;  logic [31:0] e1; logic [31:0] enb0;
    logic [1:0]  ebusy; logic estall; logic econf;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reg_write_a = 0; write_reg_a = 0; write_data_a = 0; wb_clear_a = 0;
    reg_write_b = 0; write_reg_b = 0; write_data_b = 0; wb_clear_b = 0;
    issue_valid = 0; issue_reg = 0;
  endtask

  initial begin
    //            wa aa  da            ca wb ab  db            cb iv ir  r0  r1  e0            e1            enb0          busy   st    cf
    vecs[0]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd3, 5'd4, 32'h0,       32'h0,    32'h0,    2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1, 5'd3, 32'h11,       0, 1, 5'd4, 32'h22,   0, 0, 5'd0, 5'd3, 5'd4, 32'h11,      32'h22,   32'h0,    2'b00, 1'b0, 1'b0};
    vecs[2]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd3, 5'd4, 32'h11,      32'h22,   32'h11,   2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1, 5'd7, 32'hAAAA,     0, 1, 5'd7, 32'hBBBB, 0, 0, 5'd0, 5'd7, 5'd3, 32'hBBBB,    32'h11,   32'h0,    2'b00, 1'b0, 1'b0};
    vecs[4]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd7, 5'd3, 32'hBBBB,    32'h11,   32'hBBBB, 2'b00, 1'b0, 1'b1};
    vecs[5]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd7, 5'd3, 32'hBBBB,    32'h11,   32'hBBBB, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{0, 5'd0, 32'h0,        0, 1, 5'd9, 32'h1234, 0, 0, 5'd0, 5'd9, 5'd7, 32'h1234,    32'hBBBB, 32'h0,    2'b00, 1'b0, 1'b0};
    vecs[7]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd9, 5'd7, 32'h1234,    32'hBBBB, 32'h1234, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 1, 5'd6, 5'd6, 5'd9, 32'h0,       32'h1234, 32'h0,    2'b00, 1'b0, 1'b0};
    vecs[9]  = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 1, 5'd6, 5'd6, 5'd9, 32'h0,       32'h1234, 32'h0,    2'b01, 1'b1, 1'b0};
    vecs[10] = '{1, 5'd6, 32'h66,       1, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd6, 5'd9, 32'h66,      32'h1234, 32'h0,    2'b00, 1'b0, 1'b0};
    vecs[11] = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd6, 5'd9, 32'h66,      32'h1234, 32'h66,   2'b00, 1'b0, 1'b0};
    vecs[12] = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 1, 5'd6, 5'd6, 5'd9, 32'h66,      32'h1234, 32'h66,   2'b00, 1'b0, 1'b0};
    vecs[13] = '{0, 5'd0, 32'h0,        0, 1, 5'd6, 32'h77,   1, 1, 5'd6, 5'd6, 5'd9, 32'h77,      32'h1234, 32'h66,   2'b00, 1'b1, 1'b0};
    vecs[14] = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd6, 5'd9, 32'h77,      32'h1234, 32'h77,   2'b01, 1'b0, 1'b0};
    vecs[15] = '{1, 5'd10, 32'h5,       1, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd10, 5'd6, 32'h5,      32'h77,   32'h0,    2'b10, 1'b0, 1'b0};
    vecs[16] = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 0, 5'd0, 5'd10, 5'd6, 32'h5,      32'h77,   32'h5,    2'b10, 1'b0, 1'b0};
    vecs[17] = '{1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 32'h0,    0, 1, 5'd0, 5'd0, 5'd6, 32'h0,       32'h77,   32'h0,    2'b10, 1'b0, 1'b0};
    vecs[18] = '{0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,    0, 1, 5'd0, 5'd0, 5'd0, 32'h0,       32'h0,    32'h0,    2'b00, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    read_reg = {5'd1, 5'd0};
    #1;
    chk("reset_rd0", read_data[31:0], 32'h0);
    chk("reset_rd1", read_data[63:32], 32'h0);
    chk("reset_busy", 32'(read_busy), 32'h0);
    chk("reset_conf", 32'(wr_conflict), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reg_write_a = vecs[i].wa; write_reg_a = vecs[i].aa; write_data_a = vecs[i].da;
      wb_clear_a  = vecs[i].ca;
      reg_write_b = vecs[i].wb; write_reg_b = vecs[i].ab; write_data_b = vecs[i].db;
      wb_clear_b  = vecs[i].cb;
      issue_valid = vecs[i].iv; issue_reg = vecs[i].ir;
      read_reg    = {vecs[i].r1, vecs[i].r0};
      #1;
      chk($sformatf("v%0d_rd0", i), read_data[31:0], vecs[i].e0);
      chk($sformatf("v%0d_rd1", i), read_data[63:32], vecs[i].e1);
      chk($sformatf("v%0d_nb_rd0", i), read_data_nb[31:0], vecs[i].enb0);
      chk($sformatf("v%0d_busy", i), 32'(read_busy), 32'(vecs[i].ebusy));
      chk($sformatf("v%0d_stall", i), 32'(issue_stall), 32'(vecs[i].estall));
      chk($sformatf("v%0d_conf", i), 32'(wr_conflict), 32'(vecs[i].econf));
    end

    // Asynchronous reset mid-cycle wipes data, busy bits and the conflict flag.
    @(negedge clk);
    idle_inputs();
    reg_write_a = 1; write_reg_a = 5'd5; write_data_a = 32'hDEADBEEF;
    issue_valid = 1; issue_reg = 5'd5;
    @(negedge clk);
    idle_inputs();
    reg_write_a = 1; write_reg_a = 5'd8; write_data_a = 32'h1;
    reg_write_b = 1; write_reg_b = 5'd8; write_data_b = 32'h2;
    read_reg = {5'd8, 5'd5};
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("pre_rst_r5", read_data[31:0], 32'hDEADBEEF);
    chk("pre_rst_r8", read_data[63:32], 32'h2);
    chk("pre_rst_busy", 32'(read_busy), 32'h1);
    chk("pre_rst_conf", 32'(wr_conflict), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_r5", read_data[31:0], 32'h0);
    chk("rst_r8", read_data[63:32], 32'h0);
    chk("rst_busy", 32'(read_busy), 32'h0);
    chk("rst_conf", 32'(wr_conflict), 32'h0);
    chk("rst_nb_r5", read_data_nb[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_r5", read_data[31:0], 32'h0);
    chk("post_rst_busy", 32'(read_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
